// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue.
// Holds the datapath width, the NOP encoding that decode sees when idle,
// the PC increment used by the PC register, and the ring entry layout.
package ifetch_queue_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INS_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    // One ring slot: fetch address, returned instruction, data-present flag.
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] ins;
        logic            full;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_ring.sv
// Ring storage for the fetch queue.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   i_flush         collapse the ring: head and fill jump to alloc
//   i_alloc         record i_alloc_addr in entry[alloc], mark empty, advance alloc
//   i_fill          write i_fill_data into entry[fill], mark full, advance fill
//   i_drain         advance head
//   o_occ           alloc - head (entries allocated and not yet drained)
//   o_pend          alloc - fill (requests still awaiting a response)
//   o_head          entry at head
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module ifq_ring
    import ifetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    input  logic                  i_alloc,
    input  logic [XLEN-1:0]       i_alloc_addr,
    input  logic                  i_fill,
    input  logic [XLEN-1:0]       i_fill_data,
    input  logic                  i_drain,
    output logic [$clog2(DEPTH):0] o_occ,
    output logic [$clog2(DEPTH):0] o_pend,
    output ifq_entry_t            o_head
);

    localparam int AW = $clog2(DEPTH);

    ifq_entry_t r_mem [DEPTH];
    logic [AW:0] r_alloc;
    logic [AW:0] r_fill;
    logic [AW:0] r_head;

    assign o_occ  = r_alloc - r_head;
    assign o_pend = r_alloc - r_fill;
    assign o_head = r_mem[r_head[AW-1:0]];

    // Alloc, fill and drain always land on distinct slots: fill lies in
    // [head, alloc) and alloc only fires while the ring has a free slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alloc <= '0;
            r_fill  <= '0;
            r_head  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_head <= r_alloc;
            r_fill <= r_alloc;
        end else begin
            if (i_alloc) begin
                r_mem[r_alloc[AW-1:0]].addr <= i_alloc_addr;
                r_mem[r_alloc[AW-1:0]].full <= 1'b0;
                r_alloc <= r_alloc + 1'b1;
            end
            if (i_fill) begin
                r_mem[r_fill[AW-1:0]].ins  <= i_fill_data;
                r_mem[r_fill[AW-1:0]].full <= 1'b1;
                r_fill <= r_fill + 1'b1;
            end
            if (i_drain) begin
                r_head <= r_head + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue between the PC register and decode.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   pc_addr          current PC from the PC register
//   jump_en          redirect: flush the queue, discard in-flight fetches
//   hold_en          1 = PC register must not advance this cycle
//   imem_req_*       fetch request (valid/ready), address = pc_addr
//   imem_rsp_*       in-order fetch responses, never back-pressured
//   id_valid/ready   handshake to decode
//   id_ins           instruction (NOP when id_valid = 0)
//   id_ins_addr      its PC (0 when id_valid = 0)
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_addr,
    input  logic            jump_en,
    output logic            hold_en,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            id_valid,
    output logic [XLEN-1:0] id_ins,
    output logic [XLEN-1:0] id_ins_addr,
    input  logic            id_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] LIMIT = (AW + 2)'(DEPTH);

    logic [AW:0]   w_occ;
    logic [AW:0]   w_pend;
    logic [AW:0]   r_kill;
    logic [AW+1:0] w_used;
    logic          w_req_fire;
    logic          w_killing;
    logic          w_rsp_drop;
    logic          w_rsp_fill;
    logic          w_drain;
    ifq_entry_t    w_head;

    ifq_ring #(.DEPTH(DEPTH)) u_ring (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (jump_en),
        .i_alloc      (w_req_fire),
        .i_alloc_addr (pc_addr),
        .i_fill       (w_rsp_fill),
        .i_fill_data  (imem_rsp_data),
        .i_drain      (w_drain),
        .o_occ        (w_occ),
        .o_pend       (w_pend),
        .o_head       (w_head)
    );

    always_comb begin
        // Stale responses still owed by memory occupy slots too, so a
        // redirect cannot overrun the ring with fresh requests.
        w_used         = {1'b0, w_occ} + {1'b0, r_kill};
        imem_req_valid = rst & ~jump_en & (w_used < LIMIT);
        imem_req_addr  = pc_addr;
        w_req_fire     = imem_req_valid & imem_req_ready;
        hold_en        = ~w_req_fire;

        w_killing  = (r_kill != '0);
        // A response in the flush cycle is stale; it only counts as a drop
        // when something was actually outstanding.
        w_rsp_drop = imem_rsp_valid & (w_killing | (jump_en & (w_pend != '0)));
        w_rsp_fill = imem_rsp_valid & ~jump_en & ~w_killing & (w_pend != '0);

        id_valid    = rst & (w_occ != '0) & w_head.full & ~jump_en;
        w_drain     = id_valid & id_ready;
        id_ins      = id_valid ? w_head.ins  : INS_NOP;
        id_ins_addr = id_valid ? w_head.addr : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_kill <= '0;
        end else if (jump_en) begin
            r_kill <= r_kill + w_pend - {{AW{1'b0}}, w_rsp_drop};
        end else if (w_rsp_drop) begin
            r_kill <= r_kill - 1'b1;
        end
    end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch queue between the PC register and decode. Each cycle it turns the current PC into an instruction-memory request, tracks up to `DEPTH` in-flight or buffered fetches in a ring, and presents returned instructions in order to decode through a valid/ready handshake. It back-pressures the PC register via `hold_en` and discards wrong-path fetches on `jump_en`.

## Interface
- `DEPTH`, 4: ring entries; power of two, ≥2; bounds outstanding plus buffered fetches.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `pc_addr`  in  32  current PC (`ins_addr` of PC register).
- `jump_en`  in  1  redirect/flush; same signal that loads the PC register.
- `hold_en`  out  1  to PC register; 1 = do not advance PC this cycle.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  32  fetch address (= `pc_addr`).
- `imem_req_ready`  in  1  memory accepts request.
- `imem_rsp_valid`  in  1  response valid; responses in request order, ≥1 cycle after acceptance, never back-pressured.
- `imem_rsp_data`  in  32  fetched instruction.
- `id_valid`  out  1  instruction available to decode.
- `id_ins`  out  32  instruction; `NOP` (32'h00000013) when `id_valid`=0.
- `id_ins_addr`  out  32  its PC; 0 when `id_valid`=0.
- `id_ready`  in  1  decode accepts.

## Operation
- Ring entry: {addr[31:0], ins[31:0], full}. Three pointers, each clog2(DEPTH)+1 bits with wrap bit: `alloc`, `fill`, `head`. `occ` = alloc−head; `pend` = alloc−fill.
- `kill_cnt` (clog2(DEPTH)+1 bits): stale responses still to be dropped.
- Issue: `imem_req_valid` = rst & !jump_en & (occ + kill_cnt < DEPTH). Handshake (valid & ready) writes `pc_addr` to entry[alloc], clears full, increments alloc.
- `hold_en` = !(imem_req_valid & imem_req_ready). PC advances by 4 exactly once per accepted request.
- Response: if kill_cnt≠0, drop and decrement kill_cnt. Otherwise write data to entry[fill], set full, increment fill. A response with kill_cnt=0 and pend=0 is a protocol error: ignore it; the bench asserts it never occurs.
- Drain: `id_valid` = (occ≠0) & entry[head].full & !jump_en. On `id_valid & id_ready`, increment head.
- Flush (`jump_en`=1): head, fill and alloc all set to alloc. kill_cnt ← kill_cnt + pend − (response dropped this cycle ? 1 : 0). A response arriving in the flush cycle is always treated as stale. No issue and no drain occur in the flush cycle.
- Reset: pointers and kill_cnt 0, all full bits 0. While `rst`=0: `imem_req_valid`=0, `hold_en`=1, `id_valid`=0, `id_ins`=NOP, `id_ins_addr`=0.

## Timing
- Request is combinational from state, `jump_en` and `imem_req_ready`. `hold_en` is combinational from `imem_req_ready`; the memory must not derive ready from `hold_en`.
- Response data registered. The earliest `id_valid` is the cycle after the response.
- Latency: request accepted in cycle N, 1-cycle memory responds in N+1, decode sees it in N+2.
- Throughput: 1 instruction/cycle sustained with 1-cycle memory and DEPTH≥3.
- Full (occ+kill_cnt=DEPTH): `hold_en`=1 until a drain or a killed response frees a slot. The freed slot is usable the next cycle.
- Fill, drain and allocate may occur together in one cycle on distinct entries.
- Reset mid-operation clears everything immediately. The memory side must also reset; no kill accounting carries over.

## Structure
- Shared defines header: `XLEN`=32, `INS_NOP`=32'h00000013, `PC_STEP`=4.
- One sub-module, `ifq_ring`: storage array plus the three wrap-bit pointers and `occ`/`pend`. Issue/flush/kill logic stays in `ifetch_queue`.

## Test plan
- Reset then streaming: PC 0,4,8,… with 1-cycle memory and `id_ready`=1. Expect the first `id_valid` in cycle 2, addresses 0,4,8 consecutively, and `hold_en`=0 continuously.
- Back-pressure: `id_ready`=0 with DEPTH=4. Expect exactly 4 requests (0,4,8,C), then `hold_en`=1 and `imem_req_valid`=0. Raising `id_ready` drains 0,4,8,C in order and issue resumes at 0x10.
- Flush with 2 outstanding (3-cycle memory): `jump_en` pulse to 0x100. Expect the next 2 responses dropped, no `id_valid` for old addresses, and the first delivered `id_ins_addr`=0x100.
- Flush coinciding with a response: the response is dropped and kill_cnt = pend−1. Subsequent delivery starts at the jump target.
- Memory stall: `imem_req_ready`=0 for 5 cycles. Expect `hold_en`=1 and `imem_req_addr` stable at the same PC throughout. The PC is not skipped after release.
- Async reset asserted while 3 entries are buffered: `id_valid` and `imem_req_valid` go 0 immediately without a clock edge. After release, fetching restarts cleanly from PC 0.
